// File: rtl/latch_ctrl_pkg.sv
// Shared definitions for the latch write controller: FSM state encoding and
// the phase-counter width helper.
package latch_ctrl_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        PULSE = 3'd2,
        HOLD  = 3'd3,
        CHECK = 3'd4
    } state_t;

    // The timer is loaded with (phase length - 1), so it must hold max-1.
    function automatic int cnt_w(input int setup_cyc, input int pulse_cyc, input int hold_cyc);
        int m;
        m = setup_cyc;
        if (pulse_cyc > m) m = pulse_cyc;
        if (hold_cyc > m)  m = hold_cyc;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/latch_phase_timer.sv
// Loadable down-counter that times each write phase; o_zero flags the last
// cycle of the current phase.
module latch_phase_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/latch_write_ctrl.sv
// Sequences setup / enable-pulse / hold windows for writes into a bank of
// gated D latches. Optional readback check enabled by LATCH_READBACK_EN.
module latch_write_ctrl
    import latch_ctrl_pkg::*;
#(
    parameter  int WIDTH     = 8,
    parameter  int DEPTH     = 4,
    parameter  int SETUP_CYC = 1,
    parameter  int PULSE_CYC = 2,
    parameter  int HOLD_CYC  = 1,
    localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] latch_d,
    output logic [DEPTH-1:0] latch_en,
    output logic             busy,
    output logic             done,
`ifdef LATCH_READBACK_EN
    output logic [AW-1:0]    rd_addr,
    input  logic [WIDTH-1:0] latch_q,
    output logic             rb_err,
`endif
    output logic             addr_err
);

    localparam int CW = cnt_w(SETUP_CYC, PULSE_CYC, HOLD_CYC);

    state_t           r_state;
    state_t           w_next;
    logic [AW-1:0]    r_addr;
    logic             r_addr_bad;
    logic [WIDTH-1:0] r_latch_d;
    logic [DEPTH-1:0] r_en;
    logic [DEPTH-1:0] w_en_next;
    logic             r_busy;
    logic             r_ready;
    logic             r_done;
    logic             w_done_next;
    logic             r_addr_err;
    logic             w_addr_err_next;
    logic             r_rb_err;
    logic             w_rb_err_next;
    logic             w_accept;
    logic             w_addr_ok;
    logic             w_load;
    logic [CW-1:0]    w_load_val;
    logic             w_zero;

    assign w_accept  = wr_valid && r_ready;
    assign w_addr_ok = (32'(wr_addr) < 32'(DEPTH));

    latch_phase_timer #(
        .W (CW)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_zero     (w_zero)
    );

    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        w_next          = r_state;
        w_load          = 1'b0;
        w_load_val      = '0;
        w_en_next       = r_en;
        w_done_next     = 1'b0;
        w_addr_err_next = 1'b0;
        w_rb_err_next   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next     = SETUP;
                    w_load     = 1'b1;
                    w_load_val = CW'(SETUP_CYC - 1);
                end
            end
            SETUP: begin
                if (w_zero) begin
                    w_next     = PULSE;
                    w_load     = 1'b1;
                    w_load_val = CW'(PULSE_CYC - 1);
                    w_en_next  = r_addr_bad ? '0 : (DEPTH'(1) << r_addr);
                end
            end
            PULSE: begin
                if (w_zero) begin
                    w_next     = HOLD;
                    w_load     = 1'b1;
                    w_load_val = CW'(HOLD_CYC - 1);
                    w_en_next  = '0;
                end
            end
            HOLD: begin
                if (w_zero) begin
`ifdef LATCH_READBACK_EN
                    if (r_addr_bad) begin
                        w_next          = IDLE;
                        w_done_next     = 1'b1;
                        w_addr_err_next = 1'b1;
                    end else begin
                        w_next = CHECK;
                    end
`else
                    w_next          = IDLE;
                    w_done_next     = 1'b1;
                    w_addr_err_next = r_addr_bad;
`endif
                end
            end
`ifdef LATCH_READBACK_EN
            CHECK: begin
                w_next        = IDLE;
                w_done_next   = 1'b1;
                w_rb_err_next = (latch_q != r_latch_d);
            end
`endif
            default: begin
                w_next    = IDLE;
                w_en_next = '0;
            end
        endcase
    end

    // Reset drops latch_en immediately even mid-pulse; the addressed word is
    // then left undefined, which is acceptable to the latch bank owner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_addr_bad <= 1'b0;
            r_latch_d  <= '0;
            r_en       <= '0;
            r_busy     <= 1'b0;
            r_ready    <= 1'b0;
            r_done     <= 1'b0;
            r_addr_err <= 1'b0;
            r_rb_err   <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_en       <= w_en_next;
            r_busy     <= (w_next != IDLE);
            r_ready    <= (w_next == IDLE);
            r_done     <= w_done_next;
            r_addr_err <= w_addr_err_next;
            r_rb_err   <= w_rb_err_next;
            if (w_accept) begin
                r_addr     <= wr_addr;
                r_addr_bad <= !w_addr_ok;
                r_latch_d  <= wr_data;
            end
        end
    end

    assign wr_ready = r_ready;
    assign latch_d  = r_latch_d;
    assign latch_en = r_en;
    assign busy     = r_busy;
    assign done     = r_done;
    assign addr_err = r_addr_err;
`ifdef LATCH_READBACK_EN
    assign rd_addr  = r_addr;
    assign rb_err   = r_rb_err;
`endif

endmodule
